// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream video pattern source: free-running frames of cfg_width x cfg_height pixels.
// Optional PATTERN_SRC_FRAME_CNT_EN adds a frame_count output and scrolls the horizontal ramp.
//
// state  | meaning
// IDLE   | waiting for enable with non-zero dimensions
// LATCH  | one-cycle capture of cfg_*, first beat prepared, tvalid low
// ACTIVE | streaming beats until last pixel of the frame is accepted
module axis_video_pattern_src #(
    parameter int BPC   = 8,
    parameter int DIM_W = 12
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                enable,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [1:0]          cfg_pattern,
    output logic [3*BPC-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                frame_done,
`ifdef PATTERN_SRC_FRAME_CNT_EN
    output logic [15:0]         frame_count,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_ACTIVE} state_t;

    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    width_q, width_d;
    logic [DIM_W-1:0]    height_q, height_d;
    logic [1:0]          pattern_q, pattern_d;
    logic [DIM_W-1:0]    bar_w_q, bar_w_d;
    logic [DIM_W-1:0]    x_q, x_d;
    logic [DIM_W-1:0]    y_q, y_d;
    logic [DIM_W-1:0]    bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    logic [3*BPC-1:0]    tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tuser_q, tuser_d;
    logic                tlast_q, tlast_d;
    logic                frame_done_q, frame_done_d;
    logic [DIM_W-1:0]    bar_w_cfg;
    logic [BPC-1:0]      scroll_off;
    logic                start_ok;

    function automatic logic [3*BPC-1:0] pixel(input logic [1:0]     pat,
                                               input logic [BPC-1:0] xl,
                                               input logic [BPC-1:0] yl,
                                               input logic [2:0]     b,
                                               input logic [BPC-1:0] off);
        logic [BPC-1:0] comp;
        logic [3*BPC-1:0] px;
        comp = xl + off;
        case (pat)
            2'd0:    px = '1;
            2'd1:    px = {3{comp}};
            2'd2:    px = {3{yl}};
            // bar colours fall out of the index bits: R=~b[1], G=~b[2], B=~b[0]
            default: px = {{BPC{~b[1]}}, {BPC{~b[2]}}, {BPC{~b[0]}}};
        endcase
        return px;
    endfunction

`ifdef PATTERN_SRC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // counts on the same edge frame_done rises so the next LATCH already sees the new offset
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            frame_cnt_q <= '0;
        else if (frame_done_d)
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;
    assign scroll_off  = frame_cnt_q[BPC-1:0];
`else
    assign scroll_off  = '0;
`endif

    always_comb begin
        bar_w_cfg = cfg_width >> 3;
        if (bar_w_cfg == '0)
            bar_w_cfg = DIM_ONE;
    end

    assign start_ok = enable && (cfg_width != '0) && (cfg_height != '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            pattern_q    <= '0;
            bar_w_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            pattern_q    <= pattern_d;
            bar_w_q      <= bar_w_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        pattern_d    = pattern_q;
        bar_w_d      = bar_w_q;
        x_d          = x_q;
        y_d          = y_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok)
                    state_d = ST_LATCH;
            end
            ST_LATCH: begin
                width_d   = cfg_width;
                height_d  = cfg_height;
                pattern_d = cfg_pattern;
                bar_w_d   = bar_w_cfg;
                x_d       = '0;
                y_d       = '0;
                bar_cnt_d = bar_w_cfg - DIM_ONE;
                bar_idx_d = '0;
                tvalid_d  = 1'b1;
                tuser_d   = 1'b1;
                tlast_d   = (cfg_width == DIM_ONE);
                tdata_d   = pixel(cfg_pattern, '0, '0, 3'd0, scroll_off);
                state_d   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (tvalid_q && m_axis_tready) begin
                    tuser_d = 1'b0;
                    if (x_q == width_q - DIM_ONE) begin
                        x_d       = '0;
                        bar_cnt_d = bar_w_q - DIM_ONE;
                        bar_idx_d = '0;
                        if (y_q == height_q - DIM_ONE) begin
                            y_d          = '0;
                            tvalid_d     = 1'b0;
                            tlast_d      = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = start_ok ? ST_LATCH : ST_IDLE;
                        end else begin
                            y_d     = y_q + DIM_ONE;
                            tlast_d = (width_q == DIM_ONE);
                            tdata_d = pixel(pattern_q, '0, y_d[BPC-1:0], 3'd0, scroll_off);
                        end
                    end else begin
                        x_d = x_q + DIM_ONE;
                        // bar timer: reload on terminal count, index saturates at the last bar
                        if (bar_cnt_q == '0) begin
                            bar_cnt_d = bar_w_q - DIM_ONE;
                            if (bar_idx_q != 3'd7)
                                bar_idx_d = bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q - DIM_ONE;
                        end
                        tlast_d = (x_d == width_q - DIM_ONE);
                        tdata_d = pixel(pattern_q, x_d[BPC-1:0], y_q[BPC-1:0], bar_idx_d, scroll_off);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Directed bench for axis_video_pattern_src (default build, no frame counter).
module tb_axis_video_pattern_src;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic [1:0]  cfg_pattern = '0;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tuser;
    logic        tlast;
    logic        frame_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axis_video_pattern_src #(.BPC(8), .DIM_W(12)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_pattern   (cfg_pattern),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    function automatic logic [23:0] exp_pix(input int pat, input int x, input int y, input int w);
        int bw;
        int b;
        logic [7:0] c;
        logic [23:0] p;
        case (pat)
            0: p = 24'hFFFFFF;
            1: begin c = x[7:0]; p = {c, c, c}; end
            2: begin c = y[7:0]; p = {c, c, c}; end
            default: begin
                bw = w / 8;
                if (bw == 0) bw = 1;
                b = x / bw;
                if (b > 7) b = 7;
                case (b)
                    0: p = 24'hFFFFFF;
                    1: p = 24'hFFFF00;
                    2: p = 24'h00FFFF;
                    3: p = 24'h00FF00;
                    4: p = 24'hFF00FF;
                    5: p = 24'hFF0000;
                    6: p = 24'h0000FF;
                    default: p = 24'h000000;
                endcase
            end
        endcase
        return p;
    endfunction

    task automatic test_reset();
        areset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge aclk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
        checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b want 0", tuser); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", tlast); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (tdata !== 24'h0) begin errors++; $display("FAIL rst_tdata: got %h want 000000", tdata); end
        areset = 1'b0;
        cfg_width = 12'd0; cfg_height = 12'd4; enable = 1'b1;
        repeat (4) @(negedge aclk);
        checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL zero_width: busy=%b tvalid=%b want 0 0", busy, tvalid); end
        cfg_width = 12'd4; cfg_height = 12'd0;
        repeat (4) @(negedge aclk);
        checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL zero_height: busy=%b tvalid=%b want 0 0", busy, tvalid); end
        enable = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_patterns();
        int tw[5] = '{300, 20, 16, 3, 5};
        int th[5] = '{2, 2, 2, 4, 2};
        int tp[5] = '{1, 3, 3, 2, 0};
        for (int t = 0; t < 5; t++) begin
            int beat, cyc, tu, tl, total, ex, ey;
            logic [23:0] e;
            cfg_width = 12'(tw[t]); cfg_height = 12'(th[t]); cfg_pattern = 2'(tp[t]);
            tready = 1'b1; enable = 1'b1;
            @(negedge aclk);
            checks++; if (tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL latch_cycle t%0d: tvalid=%b busy=%b want 0 1", t, tvalid, busy); end
            beat = 0; cyc = 0; tu = 0; tl = 0; total = tw[t] * th[t];
            while (beat < total && cyc < total + 10) begin
                @(negedge aclk); cyc++;
                if (tvalid) begin
                    if (beat == 0) begin
                        checks++; if (cyc != 1) begin errors++; $display("FAIL latency t%0d: first beat at cycle %0d want 2", t, cyc + 1); end
                        enable = 1'b0;
                    end
                    ex = beat % tw[t]; ey = beat / tw[t];
                    e = exp_pix(tp[t], ex, ey, tw[t]);
                    checks++; if (tdata !== e) begin errors++; $display("FAIL tdata t%0d x=%0d y=%0d: got %h want %h", t, ex, ey, tdata, e); end
                    checks++; if (tuser !== 1'(beat == 0)) begin errors++; $display("FAIL tuser t%0d beat %0d: got %b", t, beat, tuser); end
                    checks++; if (tlast !== 1'(ex == tw[t] - 1)) begin errors++; $display("FAIL tlast t%0d beat %0d: got %b", t, beat, tlast); end
                    tu += int'(tuser); tl += int'(tlast); beat++;
                end
            end
            checks++; if (beat != total) begin errors++; $display("FAIL beats t%0d: got %0d want %0d", t, beat, total); end
            @(negedge aclk);
            checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done t%0d: got %b want 1", t, frame_done); end
            checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL idle_after t%0d: busy=%b tvalid=%b want 0 0", t, busy, tvalid); end
            checks++; if (tu != 1) begin errors++; $display("FAIL tuser_count t%0d: got %0d want 1", t, tu); end
            checks++; if (tl != th[t]) begin errors++; $display("FAIL tlast_count t%0d: got %0d want %0d", t, tl, th[t]); end
            @(negedge aclk);
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse t%0d: got %b want 0", t, frame_done); end
        end
    endtask

    task automatic test_stall();
        int beat, cyc, ex, ey;
        logic stalled;
        logic [23:0] pd, e;
        logic pu, pl;
        cfg_width = 12'd20; cfg_height = 12'd3; cfg_pattern = 2'd1;
        enable = 1'b1; beat = 0; cyc = 0; stalled = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
        while (beat < 60 && cyc < 1000) begin
            @(negedge aclk); cyc++;
            if (stalled) begin
                checks++; if (tvalid !== 1'b1 || tdata !== pd || tuser !== pu || tlast !== pl) begin
                    errors++; $display("FAIL stall_hold beat %0d: got %b %h %b %b want 1 %h %b %b", beat, tvalid, tdata, tuser, tlast, pd, pu, pl);
                end
            end
            tready = 1'($urandom_range(0, 1));
            if (tvalid && tready) begin
                if (beat == 0) enable = 1'b0;
                ex = beat % 20; ey = beat / 20;
                e = exp_pix(1, ex, ey, 20);
                checks++; if (tdata !== e || tuser !== 1'(beat == 0) || tlast !== 1'(ex == 19)) begin
                    errors++; $display("FAIL stall_beat %0d: got %h %b %b want %h %b %b", beat, tdata, tuser, tlast, e, beat == 0, ex == 19);
                end
                beat++;
            end
            stalled = tvalid && !tready;
            pd = tdata; pu = tuser; pl = tlast;
        end
        checks++; if (beat != 60) begin errors++; $display("FAIL stall_beats: got %0d want 60", beat); end
        tready = 1'b1;
        @(negedge aclk);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", frame_done); end
        @(negedge aclk);
    endtask

    task automatic test_single();
        cfg_width = 12'd1; cfg_height = 12'd1; cfg_pattern = 2'd0;
        tready = 1'b1; enable = 1'b1;
        @(negedge aclk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL single_latch: tvalid=%b want 0", tvalid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            checks++; if (tvalid !== 1'b1 || tuser !== 1'b1 || tlast !== 1'b1 || tdata !== 24'hFFFFFF) begin
                errors++; $display("FAIL single_beat %0d: got v=%b u=%b l=%b d=%h want 1 1 1 ffffff", k, tvalid, tuser, tlast, tdata);
            end
            if (k == 2) enable = 1'b0;
            @(negedge aclk);
            checks++; if (frame_done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'(k < 2)) begin
                errors++; $display("FAIL single_gap %0d: got done=%b v=%b busy=%b want 1 0 %b", k, frame_done, tvalid, busy, k < 2);
            end
        end
    endtask

    task automatic test_enable_drop();
        int beat, cyc, tl;
        logic done;
        logic [23:0] e;
        cfg_width = 12'd8; cfg_height = 12'd4; cfg_pattern = 2'd1;
        tready = 1'b1; enable = 1'b1; beat = 0; cyc = 0; tl = 0; done = 1'b0;
        while (!done && cyc < 80) begin
            @(negedge aclk); cyc++;
            if (frame_done) begin
                done = 1'b1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
            end
            if (tvalid) begin
                e = exp_pix(1, beat % 8, beat / 8, 8);
                checks++; if (tdata !== e) begin errors++; $display("FAIL drop_tdata beat %0d: got %h want %h", beat, tdata, e); end
                if (beat == 5) begin enable = 1'b0; cfg_width = 12'd4; end
                tl += int'(tlast); beat++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL drop_timeout: frame_done never seen"); end
        checks++; if (beat != 32) begin errors++; $display("FAIL drop_beats: got %0d want 32", beat); end
        checks++; if (tl != 4) begin errors++; $display("FAIL drop_tlast: got %0d want 4", tl); end
        repeat (3) @(negedge aclk);
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: v=%b busy=%b want 0 0", tvalid, busy); end
        cfg_width = 12'd8;
    endtask

    task automatic test_abort();
        int beat, cyc, cnt;
        logic hit, done;
        cfg_width = 12'd8; cfg_height = 12'd4; cfg_pattern = 2'd1;
        tready = 1'b1; enable = 1'b1; beat = 0; cyc = 0; hit = 1'b0;
        while (!hit && cyc < 40) begin
            @(negedge aclk); cyc++;
            if (tvalid) begin
                if (beat == 10) hit = 1'b1;
                else beat++;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach: beat 10 not reached"); end
        areset = 1'b1;
        #1;
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0) begin
            errors++; $display("FAIL abort_now: v=%b busy=%b l=%b u=%b want 0 0 0 0", tvalid, busy, tlast, tuser);
        end
        @(negedge aclk);
        checks++; if (frame_done !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL abort_hold: done=%b v=%b want 0 0", frame_done, tvalid); end
        areset = 1'b0;
        @(negedge aclk);
        checks++; if (tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_latch: v=%b busy=%b want 0 1", tvalid, busy); end
        @(negedge aclk);
        checks++; if (tvalid !== 1'b1 || tuser !== 1'b1 || tlast !== 1'b0 || tdata !== 24'h000000) begin
            errors++; $display("FAIL abort_restart: v=%b u=%b l=%b d=%h want 1 1 0 000000", tvalid, tuser, tlast, tdata);
        end
        enable = 1'b0;
        cnt = 1; cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge aclk); cyc++;
            if (frame_done) done = 1'b1;
            else if (tvalid) cnt++;
        end
        checks++; if (!done || cnt != 32) begin errors++; $display("FAIL abort_frame: done=%b beats=%0d want 1 32", done, cnt); end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stall();
        test_single();
        test_enable_drop();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
